// File: rtl/flag_scan_detect.sv
// Chunked LSB-first all-zero / all-ones detector with a held condition-flag register.
// Walks the captured ALU result CHUNK bits per clock and exits on the first disqualifying chunk.
module flag_scan_detect #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] result,
  input  logic             mode,
  input  logic             carry_in,
  input  logic             clear_flags,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             sign,
  output logic             carry,
  output logic             flags_valid
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SH_W  = $clog2(WIDTH) + 1;

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("flag_scan_detect: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               mode_q, mode_d;
  logic               cin_q, cin_d;
  logic               chain_q, chain_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;
  logic               sign_q, sign_d;
  logic               carry_q, carry_d;
  logic               fv_q, fv_d;

  logic [SH_W-1:0]    shamt;
  logic [CHUNK-1:0]   chunk;
  logic               disq;
  logic               last;
  logic               term;

  // Current chunk and its termination condition
  always_comb begin
    shamt = SH_W'(idx_q) * SH_W'(CHUNK);
    chunk = CHUNK'(res_q >> shamt);
    disq  = mode_q ? ~(&chunk) : (|chunk);
    last  = (idx_q == IDX_W'(N - 1));
    term  = (state_q == S_SCAN) && (disq || last);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      chain_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      chain_q <= chain_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (term)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and flag updates; a terminating scan overrides a coincident clear
  always_comb begin
    res_d   = res_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    chain_d = chain_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    sign_d  = sign_q;
    carry_d = carry_q;
    fv_d    = fv_q;

    if (clear_flags) begin
      zero_d  = 1'b0;
      sign_d  = 1'b0;
      carry_d = 1'b0;
      fv_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          res_d   = result;
          mode_d  = mode;
          cin_d   = carry_in;
          chain_d = 1'b1;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (term) begin
          zero_d  = chain_q & ~disq;
          sign_d  = res_q[WIDTH-1];
          carry_d = cin_q;
          fv_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy        = (state_q == S_SCAN);
  assign done        = done_q;
  assign zero        = zero_q;
  assign sign        = sign_q;
  assign carry       = carry_q;
  assign flags_valid = fv_q;

endmodule

// File: tb/tb_flag_scan_detect.sv
// Scoreboard bench for flag_scan_detect: three parametrisations, directed vectors,
// expected flags/latency queued at issue time and checked by a monitor on each done.
module tb_flag_scan_detect;

  typedef struct packed {
    int   k;
    logic z;
    logic s;
    logic c;
    int   cyc;
    int   lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] res16;
  logic        mode;
  logic        carry_in;
  logic        clear_flags;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        zero_v  [3];
  logic        sign_v  [3];
  logic        carry_v [3];
  logic        fv_v    [3];

  int   n_chk;
  int   n_err;
  int   cyc;
  exp_t sb [$];
  exp_t mon_e;
  int   busy_cnt  [3];
  logic prev_done [3];

  flag_scan_detect #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .result(res16[7:0]), .mode(mode),
    .carry_in(carry_in), .clear_flags(clear_flags), .busy(busy_v[0]), .done(done_v[0]),
    .zero(zero_v[0]), .sign(sign_v[0]), .carry(carry_v[0]), .flags_valid(fv_v[0])
  );

  flag_scan_detect #(.WIDTH(16), .CHUNK(4)) u_w16c4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .result(res16), .mode(mode),
    .carry_in(carry_in), .clear_flags(clear_flags), .busy(busy_v[1]), .done(done_v[1]),
    .zero(zero_v[1]), .sign(sign_v[1]), .carry(carry_v[1]), .flags_valid(fv_v[1])
  );

  flag_scan_detect #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .result(res16[7:0]), .mode(mode),
    .carry_in(carry_in), .clear_flags(clear_flags), .busy(busy_v[2]), .done(done_v[2]),
    .zero(zero_v[2]), .sign(sign_v[2]), .carry(carry_v[2]), .flags_valid(fv_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int any_out();
    int r = 0;
    for (int k = 0; k < 3; k++)
      r = r | int'(busy_v[k] | done_v[k] | zero_v[k] | sign_v[k] | carry_v[k] | fv_v[k]);
    return r;
  endfunction

  // Called on a falling edge; start is held through exactly one rising edge.
  task automatic issue(input int k, input logic [15:0] r, input logic md, input logic cin,
                       input logic z, input logic s, input logic c, input int lat,
                       input bit expect_done);
    exp_t e;
    res16      = r;
    mode       = md;
    carry_in   = cin;
    start_v[k] = 1'b1;
    if (expect_done) begin
      e.k = k; e.z = z; e.s = s; e.c = c; e.cyc = cyc + 1 + lat; e.lat = lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("timeout_pending", sb.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        busy_cnt[k]  = 0;
        prev_done[k] = 1'b0;
      end else begin
        if (done_v[k]) begin
          chk("done_twice", int'(prev_done[k]), 0);
          if (sb.size() == 0) begin
            chk("spurious_done", int'(done_v[k]), 0);
          end else begin
            mon_e = sb.pop_front();
            chk("instance",    k,               mon_e.k);
            chk("zero",        int'(zero_v[k]),  int'(mon_e.z));
            chk("sign",        int'(sign_v[k]),  int'(mon_e.s));
            chk("carry",       int'(carry_v[k]), int'(mon_e.c));
            chk("flags_valid", int'(fv_v[k]),    1);
            chk("done_cycle",  cyc,              mon_e.cyc);
            chk("busy_cycles", busy_cnt[k],      mon_e.lat);
          end
          busy_cnt[k] = busy_v[k] ? 1 : 0;
        end else if (busy_v[k]) begin
          busy_cnt[k]++;
        end
        prev_done[k] = done_v[k];
      end
    end
  end

  initial begin
    int c;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    res16 = '0;
    mode = 1'b0;
    carry_in = 1'b0;
    clear_flags = 1'b0;
    for (int k = 0; k < 3; k++) start_v[k] = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", any_out(), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", any_out(), 0);
    end

    // W8/C2 basic vectors
    issue(0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b1); wait_idle();
    issue(0, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1); wait_idle();
    issue(0, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1); wait_idle();
    issue(0, 16'h00FF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b1); wait_idle();
    issue(0, 16'h00FE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b1); wait_idle();

    // start pulsed at E2 of a running scan is dropped
    issue(0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 1'b1);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // start held through the done cycle; inputs change mid-scan
    begin
      exp_t e;
      c = cyc;
      res16 = 16'h0000; mode = 1'b0; carry_in = 1'b1; start_v[0] = 1'b1;
      e.k = 0; e.z = 1'b1; e.s = 1'b0; e.c = 1'b1; e.cyc = c + 5; e.lat = 4;
      sb.push_back(e);
      @(negedge clk);
      res16 = 16'h00FE; mode = 1'b1; carry_in = 1'b0;
      e.k = 0; e.z = 1'b0; e.s = 1'b1; e.c = 1'b0; e.cyc = c + 7; e.lat = 1;
      sb.push_back(e);
      repeat (5) @(negedge clk);
      start_v[0] = 1'b0;
      wait_idle();
    end

    // clear coincident with termination: new flags survive
    issue(0, 16'h00FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b1);
    repeat (3) @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    wait_idle();

    // clear while idle
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("clr_zero",  int'(zero_v[0]),  0);
    chk("clr_sign",  int'(sign_v[0]),  0);
    chk("clr_carry", int'(carry_v[0]), 0);
    chk("clr_fv",    int'(fv_v[0]),    0);

    // reset in cycle 2 of a scan
    issue(0, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b1); wait_idle();
    issue(0, 16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    @(negedge clk);
    chk("busy_before_rst", int'(busy_v[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", any_out(), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("after_abort_outputs", any_out(), 0);

    // W16/C4
    issue(1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b1); wait_idle();
    issue(1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1); wait_idle();
    issue(1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1); wait_idle();

    // W8/C1
    issue(2, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b1); wait_idle();
    issue(2, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1); wait_idle();
    issue(2, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8, 1'b1); wait_idle();

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
